pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_unit_pkg.sv | 40 ++++
 rtl/pc_unit_if.sv | 42 ++++
 rtl/pc_unit_npc_sel.sv | 80 ++++++++
 rtl/pc_unit.sv | 53 +++++
 tb/tb_pc_unit.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/pc_unit_pkg.sv
// ----------------------------------------------------------------------------
// pc_unit_pkg
//   Shared address map for the fetch stage plus the small types and helpers
//   used by the PC logic.
//
//   Contents:
//     PC_RESET        first fetch address after reset
//     PC_HANDLER      exception / interrupt entry point
//     VALID_PC_START  lowest legal instruction address
//     VALID_PC_END    highest legal instruction address (word aligned)
//     npc_src_e       which source feeds the next PC
//     pc_add()        32-bit modulo address increment
// ----------------------------------------------------------------------------
package pc_unit_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] PC_RESET       = 32'h0000_3000;
    localparam logic [PC_W-1:0] PC_HANDLER     = 32'h0000_4180;
    localparam logic [PC_W-1:0] VALID_PC_START = 32'h0000_3000;
    localparam logic [PC_W-1:0] VALID_PC_END   = 32'h0000_6ffc;

    localparam logic [PC_W-1:0] PC_STEP = 32'd4;
    localparam logic [PC_W-1:0] PC_LINK = 32'd8;

    typedef enum logic [2:0] {
        SEL_HANDLER,
        SEL_HOLD,
        SEL_EPC,
        SEL_NPC,
        SEL_SEQ
    } npc_src_e;

    // Addresses wrap modulo 2^32; the carry out is deliberately discarded.
    function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] pc,
                                               input logic [PC_W-1:0] inc);
        return pc + inc;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// ----------------------------------------------------------------------------
// pc_unit_if
//   Bundle of control inputs and fetch outputs exchanged between the
//   pipeline (master) and the PC unit (slave).
//
//   Signals:
//     stall      hazard stall from D stage
//     req        exception / interrupt request from CP0
//     eret_d     ERET decoded in D stage
//     epc        exception return address
//     npc_valid  branch taken or jump in D stage
//     npc        branch / jump target
//     jump_d     D-stage instruction is a branch or jump
//     pc_f       fetch address
//     pc8_f      pc_f + 8 (link address)
//     bd_f       fetched instruction sits in a branch delay slot
// ----------------------------------------------------------------------------
interface pc_unit_if;
    import pc_unit_pkg::*;

    logic            stall;
    logic            req;
    logic            eret_d;
    logic [PC_W-1:0] epc;
    logic            npc_valid;
    logic [PC_W-1:0] npc;
    logic            jump_d;
    logic [PC_W-1:0] pc_f;
    logic [PC_W-1:0] pc8_f;
    logic            bd_f;

    modport master (
        output stall, req, eret_d, epc, npc_valid, npc, jump_d,
        input  pc_f, pc8_f, bd_f
    );

    modport slave (
        input  stall, req, eret_d, epc, npc_valid, npc, jump_d,
        output pc_f, pc8_f, bd_f
    );

endinterface

// File: rtl/pc_unit_npc_sel.sv
// ----------------------------------------------------------------------------
// npc_sel
//   Combinational next-PC / next-delay-slot selection for the fetch stage.
//   Priority, highest first: req, stall, eret_d, npc_valid, sequential.
//   Reset is applied at the register in pc_unit and therefore outranks all
//   of these.
//
//   Ports:
//     req, stall, eret_d, npc_valid, jump_d  control inputs
//     epc, npc                               redirect targets
//     pc_cur, bd_cur                         current register contents
//     pc_next, bd_next                       values to load on the next edge
// ----------------------------------------------------------------------------
module npc_sel
    import pc_unit_pkg::*;
(
    input  logic            req,
    input  logic            stall,
    input  logic            eret_d,
    input  logic            npc_valid,
    input  logic            jump_d,
    input  logic [PC_W-1:0] epc,
    input  logic [PC_W-1:0] npc,
    input  logic [PC_W-1:0] pc_cur,
    input  logic            bd_cur,
    output logic [PC_W-1:0] pc_next,
    output logic            bd_next
);

    npc_src_e src;

    always_comb begin
        src = SEL_SEQ;
        if (req) begin
            src = SEL_HANDLER;
        end else if (stall) begin
            src = SEL_HOLD;
        end else if (eret_d) begin
            src = SEL_EPC;
        end else if (npc_valid) begin
            src = SEL_NPC;
        end
    end

    // Targets pass through untouched; alignment and range faults are
    // flagged further down the pipe.
    always_comb begin
        pc_next = pc_add(pc_cur, PC_STEP);
        bd_next = jump_d;
        unique case (src)
            SEL_HANDLER: begin
                pc_next = PC_HANDLER;
                bd_next = 1'b0;
            end
            SEL_HOLD: begin
                pc_next = pc_cur;
                bd_next = bd_cur;
            end
            SEL_EPC: begin
                // ERET has no delay slot.
                pc_next = epc;
                bd_next = 1'b0;
            end
            SEL_NPC: begin
                // Delay-slot flag follows jump_d, not npc_valid.
                pc_next = npc;
                bd_next = jump_d;
            end
            SEL_SEQ: begin
                pc_next = pc_add(pc_cur, PC_STEP);
                bd_next = jump_d;
            end
            default: begin
                pc_next = pc_add(pc_cur, PC_STEP);
                bd_next = jump_d;
            end
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit
//   Fetch-stage program counter. Holds pc_f and the branch-delay-slot flag
//   bd_f in registers; the next value is chosen by npc_sel. A redirect
//   sampled on one rising edge is visible on pc_f right after that edge.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous active-high reset; loads PC_RESET, clears bd_f
//     bus    pc_unit_if.slave: control inputs, pc_f / pc8_f / bd_f outputs
// ----------------------------------------------------------------------------
module pc_unit
    import pc_unit_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    pc_unit_if.slave     bus
);

    logic [PC_W-1:0] pc_q;
    logic            bd_q;
    logic [PC_W-1:0] pc_next;
    logic            bd_next;

    npc_sel u_npc_sel (
        .req       (bus.req),
        .stall     (bus.stall),
        .eret_d    (bus.eret_d),
        .npc_valid (bus.npc_valid),
        .jump_d    (bus.jump_d),
        .epc       (bus.epc),
        .npc       (bus.npc),
        .pc_cur    (pc_q),
        .bd_cur    (bd_q),
        .pc_next   (pc_next),
        .bd_next   (bd_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
            bd_q <= 1'b0;
        end else begin
            pc_q <= pc_next;
            bd_q <= bd_next;
        end
    end

    assign bus.pc_f  = pc_q;
    assign bus.bd_f  = bd_q;
    assign bus.pc8_f = pc_add(pc_q, PC_LINK);

endmodule

// File: tb/tb_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_unit
//   Directed bench for pc_unit: walks through reset, sequential fetch,
//   branch with delay slot, stall, exception redirect, ERET, address
//   wrap-around, target pass-through and reset override.
// ----------------------------------------------------------------------------
module tb_pc_unit;

    logic clk;
    logic reset;
    int   passed;
    int   total;

    pc_unit_if bus ();

    pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] pc, input logic bd);
        chk({tag, ".pc_f"}, bus.pc_f, pc);
        chk({tag, ".bd_f"}, {31'd0, bus.bd_f}, {31'd0, bd});
    endtask

    task automatic idle();
        bus.stall     = 1'b0;
        bus.req       = 1'b0;
        bus.eret_d    = 1'b0;
        bus.npc_valid = 1'b0;
        bus.jump_d    = 1'b0;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        bus.epc = 32'h0;
        bus.npc = 32'h0;
        idle();

        // Reset two cycles, then three free-running cycles.
        step();
        step();
        chk_pc("reset", 32'h0000_3000, 1'b0);
        chk("reset.pc8_f", bus.pc8_f, 32'h0000_3008);
        reset = 1'b0;
        step();
        chk_pc("seq1", 32'h0000_3004, 1'b0);
        step();
        chk_pc("seq2", 32'h0000_3008, 1'b0);
        step();
        chk_pc("seq3", 32'h0000_300c, 1'b0);
        chk("seq3.pc8_f", bus.pc8_f, 32'h0000_3014);

        // Reset mid-run, then advance to 0x3008.
        reset = 1'b1;
        step();
        chk_pc("rerun_reset", 32'h0000_3000, 1'b0);
        reset = 1'b0;
        step();
        step();
        chk_pc("rerun_seq", 32'h0000_3008, 1'b0);

        // Taken branch with delay slot.
        bus.jump_d = 1'b1; bus.npc_valid = 1'b1; bus.npc = 32'h0000_3100;
        step();
        chk_pc("branch", 32'h0000_3100, 1'b1);
        idle();
        step();
        chk_pc("branch_next", 32'h0000_3104, 1'b0);

        // Redirect to 0x3010, then stall three cycles with a pending branch.
        bus.npc_valid = 1'b1; bus.npc = 32'h0000_3010;
        step();
        chk_pc("jump_3010", 32'h0000_3010, 1'b0);
        bus.stall = 1'b1; bus.npc = 32'h0000_5000; bus.jump_d = 1'b1;
        step();
        chk_pc("stall1", 32'h0000_3010, 1'b0);
        step();
        chk_pc("stall2", 32'h0000_3010, 1'b0);
        step();
        chk_pc("stall3", 32'h0000_3010, 1'b0);
        idle();
        step();
        chk_pc("stall_release", 32'h0000_3014, 1'b0);

        // Not-taken branch sets bd_f; stall holds bd_f = 1.
        bus.jump_d = 1'b1;
        step();
        chk_pc("not_taken", 32'h0000_3018, 1'b1);
        bus.jump_d = 1'b0; bus.stall = 1'b1;
        step();
        chk_pc("stall_bd", 32'h0000_3018, 1'b1);
        idle();
        step();
        chk_pc("after_bd", 32'h0000_301c, 1'b0);
        step();
        chk_pc("at_3020", 32'h0000_3020, 1'b0);

        // Stall + req (+ other redirects) -> handler, bd cleared.
        bus.stall = 1'b1; bus.req = 1'b1; bus.jump_d = 1'b1;
        bus.eret_d = 1'b1; bus.epc = 32'h0000_3abc;
        bus.npc_valid = 1'b1; bus.npc = 32'h0000_5000;
        step();
        chk_pc("handler", 32'h0000_4180, 1'b0);
        idle();
        step();
        chk_pc("handler_free", 32'h0000_4184, 1'b0);
        step();
        step();
        step();
        chk_pc("at_4190", 32'h0000_4190, 1'b0);

        // ERET beats npc_valid; no delay slot.
        bus.eret_d = 1'b1; bus.epc = 32'h0000_3024;
        bus.npc_valid = 1'b1; bus.npc = 32'h0000_5000; bus.jump_d = 1'b1;
        step();
        chk_pc("eret", 32'h0000_3024, 1'b0);
        idle();

        // Wrap-around at the top of the address space.
        bus.npc_valid = 1'b1; bus.npc = 32'hffff_fffc;
        step();
        chk_pc("top", 32'hffff_fffc, 1'b0);
        chk("top.pc8_f", bus.pc8_f, 32'h0000_0004);
        idle();
        step();
        chk_pc("wrap", 32'h0000_0000, 1'b0);
        chk("wrap.pc8_f", bus.pc8_f, 32'h0000_0008);

        // Misaligned, out-of-range target passes through.
        bus.npc_valid = 1'b1; bus.npc = 32'h0000_7001;
        step();
        chk_pc("misaligned", 32'h0000_7001, 1'b0);

        // Reset overrides req and stall.
        idle();
        reset = 1'b1; bus.req = 1'b1; bus.stall = 1'b1; bus.jump_d = 1'b1;
        step();
        chk_pc("reset_override", 32'h0000_3000, 1'b0);
        reset = 1'b0;
        idle();
        step();
        chk_pc("post_reset", 32'h0000_3004, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
